// File: rtl/dmx_frame_tx.sv
// DMX512 frame transmitter.
// Holds NUM_CH channel levels and sends continuous DMX frames while tx_en is
// high. Each frame is BREAK (line low), then MAB (line high), then NUM_CH+1
// slots. Each slot is 11 bits: start bit 0, eight data bits LSB first, and two
// stop bits 1. Slot 0 carries start code 0x00 and slot k carries channel k.
//
// Write strobe: SPIDone is a one-cycle strobe. There is no ready signal, so the
// block accepts every write on the edge where it is sampled high. The write
// takes effect only when 1 <= param <= NUM_CH; any other param is dropped.
module dmx_frame_tx #(
  parameter int CLKS_PER_BIT = 96,
  parameter int NUM_CH       = 16,
  parameter int BREAK_BITS   = 23,
  parameter int MAB_BITS     = 3
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [7:0] param,
  input  logic [7:0] value,
  input  logic       SPIDone,
  input  logic       tx_en,
  output logic       dmx_tx,
  output logic       dmx_de,
  output logic       frame_start
);

  // Counter widths. The bit index is shared by BREAK, MAB and SLOT, so it must
  // be wide enough for the longest of the three phases.
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_MAX = (BREAK_BITS > MAB_BITS) ?
                           ((BREAK_BITS > 11) ? BREAK_BITS : 11) :
                           ((MAB_BITS > 11) ? MAB_BITS : 11);
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int SLOT_W  = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  BRK_LAST  = IDX_W'(BREAK_BITS - 1);
  localparam logic [IDX_W-1:0]  MAB_LAST  = IDX_W'(MAB_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(10);
  localparam logic [IDX_W-1:0]  DATA_LO   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  DATA_HI   = IDX_W'(8);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BREAK = 2'd1;
  localparam logic [1:0] ST_MAB   = 2'd2;
  localparam logic [1:0] ST_SLOT  = 2'd3;

  logic [1:0]        state_q,       state_d;
  logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q,     bit_idx_d;
  logic [SLOT_W-1:0] slot_idx_q,    slot_idx_d;
  logic [7:0]        shift_q,       shift_d;
  logic              frame_start_q, frame_start_d;

  logic [7:0] chan_q [1:NUM_CH];
  logic [7:0] next_byte;
  logic       bit_end;

  assign bit_end = (bit_cnt_q == CNT_LAST);

  // Channel register file. An out-of-range param matches no entry, so the write is dropped.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= NUM_CH; k++) chan_q[k] <= 8'h00;
    end else if (SPIDone) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (param == 8'(k)) chan_q[k] <= value;
      end
    end
  end

  // Byte for the slot after the current one; sampled when the next start bit begins
  always_comb begin
    next_byte = 8'h00;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (int'(slot_idx_q) + 1 == k) next_byte = chan_q[k];
    end
  end

  // Next-state logic: the bit counter times each bit, and the bit index counts bits within a phase
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    bit_idx_d     = bit_idx_q;
    slot_idx_d    = slot_idx_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        slot_idx_d = '0;
        shift_d    = 8'h00;
        if (tx_en) begin
          state_d       = ST_BREAK;
          frame_start_d = 1'b1;
        end
      end
      ST_BREAK: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == BRK_LAST) begin
            state_d   = ST_MAB;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_MAB: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == MAB_LAST) begin
            // Enter slot 0 with the DMX start code loaded.
            state_d    = ST_SLOT;
            bit_idx_d  = '0;
            slot_idx_d = '0;
            shift_d    = 8'h00;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_SLOT: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (slot_idx_q == SLOT_LAST) begin
              // The frame is complete. tx_en is sampled only here, so a frame is never cut short.
              slot_idx_d = '0;
              shift_d    = 8'h00;
              if (tx_en) begin
                state_d       = ST_BREAK;
                frame_start_d = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              // Latch on the start-bit edge. A same-edge write is not seen here
              // (it shows up next frame), because chan_q still holds the old value.
              slot_idx_d = slot_idx_q + 1'b1;
              shift_d    = next_byte;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q >= DATA_LO && bit_idx_q <= DATA_HI) begin
              shift_d = {1'b0, shift_q[7:1]};
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        slot_idx_d = '0;
        shift_d    = 8'h00;
      end
    endcase
  end

  // State and timing registers. An asynchronous reset aborts any frame in progress.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      bit_idx_q     <= '0;
      slot_idx_q    <= '0;
      shift_q       <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_idx_q     <= bit_idx_d;
      slot_idx_q    <= slot_idx_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Line level is decoded from the registered state, so reset forces it to mark at once
  always_comb begin
    dmx_tx = 1'b1;
    case (state_q)
      ST_IDLE:  dmx_tx = 1'b1;
      ST_BREAK: dmx_tx = 1'b0;
      ST_MAB:   dmx_tx = 1'b1;
      ST_SLOT: begin
        if (bit_idx_q == '0)          dmx_tx = 1'b0;
        else if (bit_idx_q <= DATA_HI) dmx_tx = shift_q[0];
        else                          dmx_tx = 1'b1;
      end
      default:  dmx_tx = 1'b1;
    endcase
  end

  assign dmx_de      = (state_q != ST_IDLE);
  assign frame_start = frame_start_q;

endmodule
